// File: rtl/infinity_mem_responder.sv
// rtl/infinity_mem_responder.sv - two-phase program/data memory responder on a shared tri-state bus
// FETCH serves program bytes, DATA serves data-memory reads/writes selected by the strobes.
module infinity_mem_responder (
  input  logic       clk,
  input  logic       rst_bar,
  input  logic [7:0] MAddr,
  inout  wire  [7:0] MData,
  input  logic       ram_en_bar,
  input  logic       re_bar,
  input  logic       we_bar,
  input  logic       prog_we,
  input  logic [6:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic       phase,
  output logic       bus_err,
  output logic [7:0] rd_count,
  output logic [7:0] wr_count
);

  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} phase_t;

  phase_t     state;
  logic [7:0] pmem [128];
  logic [7:0] dmem [128];

  logic [6:0] idx;
  logic       out_of_range;
  logic       sel;
  logic       rd_ok;
  logic       wr_ok;
  logic       conflict;
  logic       drive_en;
  logic [7:0] dout;

  assign idx          = MAddr[6:0];
  assign out_of_range = MAddr[7];
  assign sel          = (state == DATA) && !ram_en_bar;
  assign rd_ok        = sel && !re_bar && we_bar;
  assign wr_ok        = sel && re_bar && !we_bar;
  assign conflict     = sel && !re_bar && !we_bar;

  // rst_bar gates the drive directly so the bus floats the instant reset asserts.
  assign drive_en = rst_bar && ((state == FETCH) || rd_ok);
  assign dout     = (state == FETCH) ? pmem[idx] : (out_of_range ? 8'h00 : dmem[idx]);
  assign MData    = drive_en ? dout : 8'bz;

  assign phase = state;

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state    <= FETCH;
      bus_err  <= 1'b0;
      rd_count <= 8'h00;
      wr_count <= 8'h00;
    end else begin
      state <= (state == FETCH) ? DATA : FETCH;
      if (conflict || ((rd_ok || wr_ok) && out_of_range))
        bus_err <= 1'b1;
      if (rd_ok && (rd_count != 8'hFF))
        rd_count <= rd_count + 8'h01;
      if (wr_ok && (wr_count != 8'hFF))
        wr_count <= wr_count + 8'h01;
    end
  end

  // Memories carry no reset; a write is only possible in DATA, which reset leaves immediately.
  always_ff @(posedge clk) begin
    if (prog_we)
      pmem[prog_addr] <= prog_data;
    if (wr_ok && !out_of_range && rst_bar)
      dmem[idx] <= MData;
  end

endmodule

// File: tb/tb_infinity_mem_responder.sv
// tb/tb_infinity_mem_responder.sv - randomized scoreboard bench for infinity_mem_responder
// The bus is pulled up, so an undriven MData reads as 8'hFF.
`timescale 1ns/100ps
module tb_infinity_mem_responder;

  localparam logic [7:0] FLOAT = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_bar;
  logic [7:0] MAddr;
  logic       ram_en_bar, re_bar, we_bar;
  logic       prog_we;
  logic [6:0] prog_addr;
  logic [7:0] prog_data;
  logic       phase, bus_err;
  logic [7:0] rd_count, wr_count;
  tri1  [7:0] MData;
  logic       tb_drive;
  logic [7:0] tb_data;

  assign MData = tb_drive ? tb_data : 8'bz;

  always #5 clk = ~clk;

  infinity_mem_responder dut (
    .clk(clk), .rst_bar(rst_bar), .MAddr(MAddr), .MData(MData),
    .ram_en_bar(ram_en_bar), .re_bar(re_bar), .we_bar(we_bar),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .phase(phase), .bus_err(bus_err), .rd_count(rd_count), .wr_count(wr_count)
  );

  typedef struct {
    string      name;
    realtime    t;
    logic [7:0] data;
    logic       ph;
    logic       err;
    logic [7:0] rc;
    logic [7:0] wc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: memories, phase, sticky error and counters, plus the inputs of the cycle in flight.
  logic [7:0] pmem [128];
  logic [7:0] dmem [128];
  logic       m_phase, m_err;
  int         m_rc, m_wc;
  logic [7:0] p_a, p_wd, p_pd;
  logic       p_ren, p_re, p_we, p_pw;
  logic [6:0] p_pa;

  task automatic push(input string nm, input logic [7:0] d);
    exp_t e;
    e.name = nm; e.t = $realtime + 2.0; e.data = d;
    e.ph = m_phase; e.err = m_err; e.rc = 8'(m_rc); e.wc = 8'(m_wc);
    exp_q.push_back(e);
  endtask

  task automatic model_edge();
    if (p_pw) pmem[p_pa] = p_pd;
    if (!rst_bar) begin
      m_phase = 1'b0;
      return;
    end
    if (m_phase && !p_ren) begin
      if (!p_re && !p_we) m_err = 1'b1;
      else if (!p_re || !p_we) begin
        if (p_a[7]) m_err = 1'b1;
        if (!p_re) m_rc = (m_rc >= 255) ? 255 : m_rc + 1;
        else begin
          m_wc = (m_wc >= 255) ? 255 : m_wc + 1;
          if (!p_a[7]) dmem[p_a[6:0]] = p_wd;
        end
      end
    end
    m_phase = !m_phase;
  endtask

  task automatic step(input logic [7:0] a, input logic ren, input logic re, input logic we,
                      input logic [7:0] wd, input logic pw, input logic [6:0] pa,
                      input logic [7:0] pd, input string nm);
    logic       drv;
    logic [7:0] d;
    @(posedge clk);
    model_edge();
    #1;
    MAddr = a; ram_en_bar = ren; re_bar = re; we_bar = we;
    prog_we = pw; prog_addr = pa; prog_data = pd;
    drv = m_phase && !ren && re && !we;
    tb_data = wd; tb_drive = drv;
    if (!rst_bar)                     d = FLOAT;
    else if (!m_phase)                d = pmem[a[6:0]];
    else if (!ren && !re && we)       d = a[7] ? 8'h00 : dmem[a[6:0]];
    else if (drv)                     d = wd;
    else                              d = FLOAT;
    push(nm, d);
    p_a = a; p_ren = ren; p_re = re; p_we = we; p_wd = wd;
    p_pw = pw; p_pa = pa; p_pd = pd;
  endtask

  task automatic data(input logic [7:0] a, input logic ren, input logic re, input logic we,
                      input logic [7:0] wd, input string nm);
    step(a, ren, re, we, wd, 1'b0, 7'h00, 8'h00, nm);
  endtask

  task automatic fetch(input logic [7:0] a, input string nm);
    step(a, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 7'h00, 8'h00, nm);
  endtask

  task automatic reset_mid(input string nm);
    #3;
    rst_bar = 1'b0; tb_drive = 1'b0; prog_we = 1'b0;
    m_phase = 1'b0; m_err = 1'b0; m_rc = 0; m_wc = 0;
    p_ren = 1'b1; p_pw = 1'b0;
    push(nm, FLOAT);
  endtask

  task automatic release_reset();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst_bar = 1'b1;
  endtask

  task automatic rand_pair(input string nm);
    int         r;
    logic [7:0] a, wd;
    logic       pw;
    r  = $urandom_range(0, 5);
    a  = 8'($urandom);
    wd = 8'($urandom);
    pw = ($urandom_range(0, 3) == 0);
    case (r)
      0, 1:    step(a, 1'b0, 1'b0, 1'b1, wd, pw, 7'($urandom), 8'($urandom), nm);
      2, 3:    step(a, 1'b0, 1'b1, 1'b0, wd, pw, 7'($urandom), 8'($urandom), nm);
      4:       step(a, 1'b0, 1'b0, 1'b0, wd, pw, 7'($urandom), 8'($urandom), nm);
      default: step(a, 1'b1, 1'($urandom), 1'($urandom), wd, pw, 7'($urandom), 8'($urandom), nm);
    endcase
    step(8'($urandom), 1'b1, 1'b1, 1'b1, 8'h00, ($urandom_range(0, 3) == 0),
         7'($urandom), 8'($urandom), {nm, "_fetch"});
  endtask

  task automatic chk(input string nm, input string fld, input logic [7:0] got, input logic [7:0] want);
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s %s: got %h expected %h", nm, fld, got, want);
    end
  endtask

  initial begin
    exp_t e;
    #0.5;
    forever begin
      #1;
      while (exp_q.size() > 0 && exp_q[0].t <= $realtime) begin
        e = exp_q.pop_front();
        n_vec++;
        chk(e.name, "MData",    MData,          e.data);
        chk(e.name, "phase",    {7'h0, phase},  {7'h0, e.ph});
        chk(e.name, "bus_err",  {7'h0, bus_err}, {7'h0, e.err});
        chk(e.name, "rd_count", rd_count,       e.rc);
        chk(e.name, "wr_count", wr_count,       e.wc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: stimulus did not complete, expected completion before 1 ms");
    $fatal(1);
  end

  initial begin
    rst_bar = 1'b0; MAddr = 8'h00; ram_en_bar = 1'b1; re_bar = 1'b1; we_bar = 1'b1;
    prog_we = 1'b0; prog_addr = 7'h00; prog_data = 8'h00; tb_drive = 1'b0; tb_data = 8'h00;
    m_phase = 1'b0; m_err = 1'b0; m_rc = 0; m_wc = 0;
    p_a = 8'h00; p_wd = 8'h00; p_ren = 1'b1; p_re = 1'b1; p_we = 1'b1;
    p_pw = 1'b0; p_pa = 7'h00; p_pd = 8'h00;
    #2;
    push("reset_state", FLOAT);
    #20;
    release_reset();

    for (int i = 0; i < 128; i++) begin
      step(8'(i), 1'b0, 1'b1, 1'b0, 8'($urandom), 1'b1, 7'(i), 8'($urandom), "preload_data");
      fetch(8'(i), "preload_fetch");
    end
    data(8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "read_before_reset");
    reset_mid("reset_after_preload");
    release_reset();

    step(8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 7'h05, 8'hC7, "load_pmem5");
    fetch(8'h05, "fetch_pmem5");
    data(8'h10, 1'b0, 1'b1, 1'b0, 8'h3A, "write_10");
    step(8'h05, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 7'h05, 8'h5E, "fetch_old_pmem5");
    data(8'h10, 1'b0, 1'b0, 1'b1, 8'h00, "read_10");
    fetch(8'h05, "fetch_new_pmem5");
    data(8'h10, 1'b1, 1'b0, 1'b1, 8'h00, "disabled_read");
    fetch(8'h10, "fetch_after_disabled");
    data(8'h10, 1'b0, 1'b1, 1'b1, 8'h00, "both_strobes_high");
    fetch(8'h00, "fetch_idle");
    data(8'h10, 1'b0, 1'b0, 1'b0, 8'h00, "conflict");
    fetch(8'h00, "fetch_after_conflict");
    data(8'h10, 1'b0, 1'b0, 1'b1, 8'h00, "read_after_conflict");
    fetch(8'h00, "fetch_idle2");
    data(8'h90, 1'b0, 1'b0, 1'b1, 8'h00, "read_out_of_range");
    fetch(8'h00, "fetch_after_oor");
    data(8'hA3, 1'b0, 1'b1, 1'b0, 8'h55, "write_out_of_range");
    for (int i = 0; i < 5; i++) begin
      fetch(8'h23, "err_sticky_fetch");
      data(8'h23, 1'b0, 1'b0, 1'b1, 8'h00, "err_sticky_read");
    end
    fetch(8'h00, "fetch_align");

    for (int i = 0; i < 300; i++) rand_pair("random");

    for (int i = 0; i < 260; i++) begin
      data({1'b0, 7'($urandom)}, 1'b0, 1'b0, 1'b1, 8'h00, "sat_read");
      fetch(8'($urandom), "sat_fetch");
    end
    data(8'h10, 1'b0, 1'b0, 1'b1, 8'h00, "read_at_saturation");
    reset_mid("reset_mid_data");
    release_reset();

    for (int i = 0; i < 20; i++) rand_pair("random_post_reset");

    repeat (2) @(posedge clk);
    #4;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
